mult_product_accumulator: RTL and testbench
===========================================

MULT_PRODUCT_ACCUMULATOR -- requirements
Module: mult_product_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4, multiplier operand width; the product input is 2*WIDTH+1 bits, matching the shift-add multiplier product register.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, accumulator and sum width; ACC_WIDTH >= 2*WIDTH+1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  product term valid, driven from the multiplier's done indication.
REQ-006 SHALL have port in_ready  output  1  block can accept a term this cycle.
REQ-007 SHALL have port product  input  2*WIDTH+1  unsigned product term.
REQ-008 SHALL have port num_terms  input  8  terms per sum; sampled only on the first term of a sum.
REQ-009 SHALL have port clear  input  1  synchronous abort; discards the partial sum.
REQ-010 SHALL have port out_valid  output  1  completed sum available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the sum.
REQ-012 SHALL have port sum  output  ACC_WIDTH  accumulated sum (partial while out_valid=0).
REQ-013 SHALL have port term_count  output  8  terms accepted into the current sum.
REQ-014 SHALL have port overflow  output  1  sticky saturation flag for the current sum.

Function
REQ-015 SHALL implement states IDLE (no partial sum), ACCUM (partial sum held), HOLD (complete sum presented).
REQ-016 SHALL drive in_ready = 1 in IDLE and ACCUM when clear=0; 0 in HOLD or when clear=1.
REQ-017 SHALL accept a term when in_valid=1 and in_ready=1 at a rising edge; no other condition accepts a term.
REQ-018 IDLE accept: SHALL latch target = num_terms (0 treated as 1), load sum = zero-extended product, term_count = 1, overflow = 0; go HOLD if target = 1, else ACCUM.
REQ-019 ACCUM accept: SHALL set sum = sum + product, term_count += 1; go HOLD when the new term_count equals target.
REQ-020 SHALL compute the addition at ACC_WIDTH+1 bits; on carry-out, sum SHALL saturate to all ones and overflow SHALL set and stay set until the sum leaves HOLD, clear, or reset.
REQ-021 SHALL assert out_valid exactly in HOLD, first the cycle after the final term is accepted (1-cycle latency).
REQ-022 In HOLD, sum, term_count and overflow SHALL remain stable until out_ready=1.
REQ-023 HOLD with out_ready=1: SHALL go IDLE next cycle, out_valid=0, sum=0, term_count=0, overflow=0; no term is accepted in that same cycle.
REQ-024 clear=1 in any state SHALL go IDLE next cycle with sum=0, term_count=0, overflow=0, out_valid=0; clear takes priority over in_valid and out_ready.
REQ-025 Changes on num_terms while in ACCUM or HOLD SHALL have no effect.
REQ-026 in_valid while in HOLD SHALL be ignored (producer must hold its term; in_ready=0).

Reset
REQ-027 rst=1 SHALL immediately force IDLE, sum=0, term_count=0, overflow=0, out_valid=0, target=1, regardless of clk.
REQ-028 Reset mid-sum SHALL discard the partial sum; the first accepted term after rst deasserts starts a new sum.
REQ-029 After reset deassertion, in_ready SHALL be 1 (when clear=0).

Verification
REQ-030 WIDTH=4, num_terms=3, terms 15, 20, 225 one per cycle, out_ready=1 -> out_valid one cycle after the third accept, sum=260, term_count=3, overflow=0, then IDLE.
REQ-031 num_terms=0, single term 49 -> treated as 1 term; next cycle out_valid=1, sum=49, term_count=1.
REQ-032 ACC_WIDTH=9, num_terms=4, terms 225 x4 -> sum saturates at 511, overflow=1 held through HOLD, cleared after out_ready handshake.
REQ-033 Sum complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, sum/term_count unchanged all 5 cycles; out_ready=1 -> IDLE, next term starts fresh sum.
REQ-034 num_terms=4, 2 terms accepted, clear=1 together with in_valid=1 -> term not accepted, sum=0, term_count=0 next cycle; following 4 terms produce the correct fresh sum.
REQ-035 rst pulsed between clock edges mid-sum (term_count=2) -> outputs zero immediately, out_valid=0; subsequent sum computed correctly from zero.

Source files
------------

// File: rtl/mult_product_accumulator.sv
// rtl/mult_product_accumulator.sv - accumulates a fixed number of multiplier product terms into a saturating sum
//
// Purpose: sums num_terms unsigned product terms coming from a shift-add
// multiplier. A complete sum is held on sum/out_valid until the consumer takes
// it; further terms are back-pressured meanwhile.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   product term handshake
//   product             unsigned product term, 2*WIDTH+1 bits
//   num_terms           terms per sum, sampled on the first term (0 means 1)
//   clear               synchronous abort of the current sum
//   out_valid/out_ready completed sum handshake
//   sum                 accumulated sum (partial while out_valid=0)
//   term_count          terms accepted into the current sum
//   overflow            sticky saturation flag for the current sum
module mult_product_accumulator #(
   parameter int WIDTH     = 4,
   parameter int ACC_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH:0]     product,
   input  logic [7:0]           num_terms,
   input  logic                 clear,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] sum,
   output logic [7:0]           term_count,
   output logic                 overflow
);

   localparam int EW = ACC_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] sum_q, sum_d;
   logic [7:0]           term_count_q, term_count_d;
   logic [7:0]           target_q, target_d;
   logic                 overflow_q, overflow_d;

   logic                 accept;
   logic [EW-1:0]        ext_sum;
   logic [7:0]           count_inc;
   logic [7:0]           first_target;

   assign in_ready     = (state_q != HOLD) && !clear;
   assign accept       = in_valid && in_ready;
   // One extra bit so the carry-out of the add is the saturation trigger.
   assign ext_sum      = EW'(sum_q) + EW'(product);
   assign count_inc    = term_count_q + 8'd1;
   assign first_target = (num_terms == 8'd0) ? 8'd1 : num_terms;

   assign out_valid  = (state_q == HOLD);
   assign sum        = sum_q;
   assign term_count = term_count_q;
   assign overflow   = overflow_q;

   always_comb begin
      state_d      = state_q;
      sum_d        = sum_q;
      term_count_d = term_count_q;
      target_d     = target_q;
      overflow_d   = overflow_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               target_d     = first_target;
               sum_d        = ACC_WIDTH'(product);
               term_count_d = 8'd1;
               overflow_d   = 1'b0;
               state_d      = (first_target == 8'd1) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (ext_sum[EW-1]) begin
                  sum_d      = '1;
                  overflow_d = 1'b1;
               end else begin
                  sum_d = ext_sum[ACC_WIDTH-1:0];
               end
               term_count_d = count_inc;
               if (count_inc == target_q) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d      = IDLE;
               sum_d        = '0;
               term_count_d = 8'd0;
               overflow_d   = 1'b0;
            end
         end
         default: begin
            state_d      = IDLE;
            sum_d        = '0;
            term_count_d = 8'd0;
            overflow_d   = 1'b0;
            target_d     = 8'd1;
         end
      endcase

      // Abort wins over any handshake in the same cycle.
      if (clear) begin
         state_d      = IDLE;
         sum_d        = '0;
         term_count_d = 8'd0;
         overflow_d   = 1'b0;
         target_d     = 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         sum_q        <= '0;
         term_count_q <= 8'd0;
         target_q     <= 8'd1;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sum_q        <= sum_d;
         term_count_q <= term_count_d;
         target_q     <= target_d;
         overflow_q   <= overflow_d;
      end
   end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// tb/tb_mult_product_accumulator.sv - self-checking bench for mult_product_accumulator
module tb_mult_product_accumulator;

   localparam int WIDTH     = 4;
   localparam int ACC_WIDTH = 9;
   localparam int SAT       = (1 << ACC_WIDTH) - 1;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [2*WIDTH:0]     product = '0;
   logic [7:0]           num_terms = 8'd1;
   logic                 clear = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [ACC_WIDTH-1:0] sum;
   logic [7:0]           term_count;
   logic                 overflow;

   int checks   = 0;
   int failures = 0;

   // Reference model: the list of accepted terms is summarised by count and
   // exact total; the saturating sum is just min(total, SAT).
   bit m_hold   = 1'b0;
   int m_count  = 0;
   int m_total  = 0;
   int m_target = 1;

   mult_product_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .product(product), .num_terms(num_terms), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .term_count(term_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hold = 1'b0; m_count = 0; m_total = 0; m_target = 1;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_hold));
      chk({tag, "_sum"}, 32'(sum), 32'((m_total > SAT) ? SAT : m_total));
      chk({tag, "_term_count"}, 32'(term_count), 32'(m_count));
      chk({tag, "_overflow"}, 32'(overflow), 32'(m_total > SAT));
   endtask

   // One clock cycle: drive inputs (called at a falling edge), check the
   // handshake before the rising edge, advance the model, check after.
   task automatic cycle(input string tag, input logic v, input int p, input int n,
                        input logic c, input logic ordy);
      bit exp_ready;
      in_valid  = v;
      product   = (2*WIDTH+1)'(p);
      num_terms = 8'(n);
      clear     = c;
      out_ready = ordy;
      #1;
      exp_ready = !m_hold && !c;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
      @(posedge clk);
      if (c) begin
         model_reset();
      end else if (m_hold) begin
         if (ordy) model_reset();
      end else if (v) begin
         if (m_count == 0) begin
            m_target = (n == 0) ? 1 : n;
            m_total  = p;
         end else begin
            m_total += p;
         end
         m_count++;
         if (m_count == m_target) m_hold = 1'b1;
      end
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_sum", 32'(sum), 0);
      chk("rst_term_count", 32'(term_count), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_overflow", 32'(overflow), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);
      @(negedge clk);

      // Three terms, 15 + 20 + 225
      cycle("t030a", 1, 15, 3, 0, 1);
      cycle("t030b", 1, 20, 7, 0, 1);
      chk("t030_not_done", 32'(out_valid), 0);
      cycle("t030c", 1, 225, 1, 0, 1);
      chk("t030_sum", 32'(sum), 260);
      chk("t030_count", 32'(term_count), 3);
      chk("t030_valid", 32'(out_valid), 1);
      cycle("t030d", 0, 0, 3, 0, 1);
      chk("t030_idle_sum", 32'(sum), 0);

      // num_terms = 0 treated as a single term
      cycle("t031a", 1, 49, 0, 0, 0);
      chk("t031_sum", 32'(sum), 49);
      chk("t031_count", 32'(term_count), 1);
      chk("t031_valid", 32'(out_valid), 1);
      cycle("t031b", 0, 0, 0, 0, 1);

      // Saturation: 4 x 225 = 900 exceeds 511
      for (int i = 0; i < 4; i++) cycle("t032acc", 1, 225, 4, 0, 0);
      chk("t032_sum", 32'(sum), 511);
      chk("t032_ovf", 32'(overflow), 1);
      cycle("t032hold", 0, 0, 4, 0, 0);
      chk("t032_ovf_held", 32'(overflow), 1);
      cycle("t032rel", 0, 0, 4, 0, 1);
      chk("t032_ovf_cleared", 32'(overflow), 0);

      // Back-pressure in HOLD
      cycle("t033a", 1, 10, 2, 0, 0);
      cycle("t033b", 1, 20, 2, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cycle("t033stall", 1, 99, 6, 0, 0);
         chk("t033_stall_sum", 32'(sum), 30);
         chk("t033_stall_count", 32'(term_count), 2);
      end
      cycle("t033rel", 1, 99, 6, 0, 1);
      chk("t033_rel_count", 32'(term_count), 0);
      cycle("t033new", 1, 7, 1, 0, 0);
      chk("t033_fresh_sum", 32'(sum), 7);
      cycle("t033drain", 0, 0, 1, 0, 1);

      // Clear with a simultaneous term
      cycle("t034a", 1, 100, 4, 0, 0);
      cycle("t034b", 1, 50, 4, 0, 0);
      cycle("t034clr", 1, 77, 4, 1, 0);
      chk("t034_sum", 32'(sum), 0);
      chk("t034_count", 32'(term_count), 0);
      cycle("t034c", 1, 1, 4, 0, 0);
      cycle("t034d", 1, 2, 9, 0, 0);
      cycle("t034e", 1, 3, 9, 0, 0);
      cycle("t034f", 1, 4, 9, 0, 0);
      chk("t034_fresh_sum", 32'(sum), 10);
      chk("t034_fresh_valid", 32'(out_valid), 1);
      cycle("t034drain", 0, 0, 1, 0, 1);

      // Asynchronous reset mid-sum
      cycle("t035a", 1, 40, 5, 0, 0);
      cycle("t035b", 1, 60, 5, 0, 0);
      rst = 1'b1;
      #1;
      chk("t035_sum", 32'(sum), 0);
      chk("t035_count", 32'(term_count), 0);
      chk("t035_valid", 32'(out_valid), 0);
      chk("t035_ovf", 32'(overflow), 0);
      #1;
      rst = 1'b0;
      model_reset();
      cycle("t035c", 1, 5, 3, 0, 0);
      cycle("t035d", 1, 6, 3, 0, 0);
      cycle("t035e", 1, 8, 3, 0, 0);
      chk("t035_fresh_sum", 32'(sum), 19);
      cycle("t035drain", 0, 0, 1, 0, 1);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         cycle("rnd",
               logic'($urandom_range(0, 3) != 0),
               int'($urandom_range(0, 225)),
               int'($urandom_range(0, 5)),
               logic'($urandom_range(0, 29) == 0),
               logic'($urandom_range(0, 2) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
